axi_lite_selftest_master: RTL
=============================

AXI_LITE_SELFTEST_MASTER -- requirements
Module: axi_lite_selftest_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the address of slave register 0.
REQ-002 SHALL have parameter NUM_REGS, default 4, meaning the number of consecutive 32-bit registers tested (range 1..16).
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port ARESET, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a test run.
REQ-006 SHALL have port busy, output, 1, high while a run is in progress.
REQ-007 SHALL have port done, output, 1, a level that is high from run completion until the next accepted start.
REQ-008 SHALL have port pass, output, 1, valid when done is high; 1 means no errors.
REQ-009 SHALL have port err_count, output, 5, the total response errors plus data errors in this run (saturating).
REQ-010 SHALL have port first_fail_idx, output, 4, the register index of the first error; 0 if none.
REQ-011 SHALL have the M_AXI AXI4-Lite master ports: AWADDR[31:0], AWPROT[2:0], AWVALID, AWREADY, WDATA[31:0], WSTRB[3:0], WVALID, WREADY, BRESP[1:0], BVALID, BREADY, ARADDR[31:0], ARPROT[2:0], ARVALID, ARREADY, RDATA[31:0], RRESP[1:0], RVALID, RREADY.

Function
REQ-012 SHALL treat start as accepted only in IDLE or DONE; start while busy SHALL be ignored.
REQ-013 SHALL use FSM states IDLE -> WR -> WR_RESP -> RD -> RD_RESP -> NEXT -> (WR or DONE); DONE -> WR on start.
REQ-014 On accepting start, SHALL clear err_count, first_fail_idx and done, set index to 0, and enter WR on the next cycle.
REQ-015 In WR, SHALL assert AWVALID and WVALID together with AWADDR = BASE_ADDR + 4*index, WDATA = pattern[index mod 4], WSTRB = 4'hF and AWPROT = 0.
REQ-016 Each of AWVALID and WVALID SHALL drop independently the cycle after its own VALID&READY handshake; the FSM SHALL move to WR_RESP once both channels have completed, in either order or in the same cycle.
REQ-017 BREADY SHALL be high only in WR_RESP; on BVALID the FSM SHALL go to RD; BRESP != 2'b00 SHALL count as one error.
REQ-018 In RD, SHALL assert ARVALID with ARADDR equal to that write's AWADDR and ARPROT = 0, and move to RD_RESP after ARREADY.
REQ-019 RREADY SHALL be high only in RD_RESP; on RVALID, SHALL count RRESP != OKAY and RDATA != expected as separate errors (up to 2 per register).
REQ-020 NEXT SHALL increment index; if the new index equals NUM_REGS the FSM SHALL enter DONE, otherwise WR.
REQ-021 VALID signals, once asserted, SHALL hold stable (address and data unchanged) until their handshake.
REQ-022 At most one transaction SHALL be outstanding; the master SHALL not issue a read before the B response of the preceding write.
REQ-023 In DONE, SHALL hold done=1 and pass=(err_count==0); busy SHALL be 1 in WR, WR_RESP, RD, RD_RESP and NEXT.
REQ-024 err_count SHALL saturate at 31; first_fail_idx SHALL latch only on the first error of the run.
REQ-025 Latency per register with zero-wait slaves SHALL be exactly 5 cycles (WR, WR_RESP, RD, RD_RESP, NEXT).

Reset
REQ-026 While ARESET is high, SHALL force the FSM to IDLE and hold all VALID/READY, busy, done, pass, err_count and first_fail_idx at 0; a reset mid-transaction SHALL abandon that transaction without completing it.

Configuration
REQ-027 With SELFTEST_TIMEOUT_EN defined, a 16-bit watchdog SHALL reload on every state change; if it stays 1024 cycles in any wait state, it SHALL count one error, drop all VALIDs and go to DONE with pass=0.
REQ-028 Without SELFTEST_TIMEOUT_EN, no watchdog logic SHALL exist, and the master SHALL wait indefinitely.

Structure
REQ-029 Package axi_lite_selftest_pkg SHALL hold the FSM state enum, the RESP_OKAY constant and the four-word pattern table {32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011}.
REQ-030 Sub-module axi_lite_selftest_watchdog SHALL contain the timeout counter, instantiated only under SELFTEST_TIMEOUT_EN.

Verification
REQ-031 Bench SHALL drive start against a zero-wait memory slave with NUM_REGS=4 -> four writes then reads at offsets 0x0, 0x4, 0x8, 0xC; done=1, pass=1, err_count=0; 20 cycles from start to done.
REQ-032 Bench SHALL have the slave assert AWREADY 3 cycles before WREADY, then the reverse -> WR_RESP entered only after both; no duplicate AW or W beat.
REQ-033 Bench SHALL have the slave return RDATA bit 0 flipped at index 2 -> err_count=1, first_fail_idx=2, pass=0.
REQ-034 Bench SHALL have the slave return BRESP=2'b10 and RRESP=2'b10 at index 1 -> err_count=2, first_fail_idx=1.
REQ-035 Bench SHALL assert ARESET during RD_RESP of index 1 -> all outputs 0 next cycle; a later start re-runs from index 0 and passes.
REQ-036 Bench SHALL, with SELFTEST_TIMEOUT_EN, hold AWREADY=0 -> done after 1024 stalled cycles, pass=0, AWVALID=0.

Source files
------------

// File: rtl/axi_lite_selftest_pkg.sv
// axi_lite_selftest_pkg: FSM states, response code, test pattern table and watchdog limit
package axi_lite_selftest_pkg;
   typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_RESP, S_NEXT, S_DONE} state_t;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [3:0][31:0] PATTERN = {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF};
   localparam logic [15:0] WDOG_LIMIT = 16'd1024;
endpackage

// File: rtl/axi_lite_selftest_watchdog.sv
// axi_lite_selftest_watchdog: stall timer for the self-test FSM, built only with SELFTEST_TIMEOUT_EN
`ifdef SELFTEST_TIMEOUT_EN
module axi_lite_selftest_watchdog
   import axi_lite_selftest_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_reload,
   input  logic i_wait,
   output logic o_timeout
);
   logic [15:0] r_cnt;
   // count cycles spent in the current wait state; any state change restarts the count
   always_ff @(posedge i_clk) begin
      if (i_rst || i_reload) r_cnt <= '0;
      else if (i_wait) r_cnt <= r_cnt + 16'd1;
   end
   assign o_timeout = i_wait && (r_cnt == WDOG_LIMIT - 16'd1);
endmodule
`endif

// File: rtl/axi_lite_selftest_master.sv
// axi_lite_selftest_master: AXI4-Lite write/read-back self-test of NUM_REGS registers; watchdog under SELFTEST_TIMEOUT_EN
module axi_lite_selftest_master
   import axi_lite_selftest_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          NUM_REGS  = 4
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  err_count,
   output logic [3:0]  first_fail_idx,
   output logic [31:0] M_AXI_AWADDR,
   output logic [2:0]  M_AXI_AWPROT,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [31:0] M_AXI_WDATA,
   output logic [3:0]  M_AXI_WSTRB,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   input  logic [1:0]  M_AXI_BRESP,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   output logic [31:0] M_AXI_ARADDR,
   output logic [2:0]  M_AXI_ARPROT,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);
   localparam logic [4:0] LP_NUM = 5'(NUM_REGS);
   state_t      r_state, w_next;
   logic [4:0]  r_idx, r_err_count;
   logic [3:0]  r_first_fail_idx;
   logic        r_aw_done, r_w_done;
   logic        w_aw_hs, w_w_hs, w_accept;
   logic [1:0]  w_err_inc;
   logic [5:0]  w_err_sum;
   logic [31:0] w_addr;
   assign w_addr = BASE_ADDR + {25'd0, r_idx, 2'b00};
   assign w_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_w_hs = M_AXI_WVALID && M_AXI_WREADY;
   assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_err_sum = {1'b0, r_err_count} + {4'd0, w_err_inc};
`ifdef SELFTEST_TIMEOUT_EN
   logic w_timeout, w_wait;
   assign w_wait = r_state == S_WR || r_state == S_WR_RESP || r_state == S_RD || r_state == S_RD_RESP;
   axi_lite_selftest_watchdog u_wdog (
      .i_clk     (ACLK),
      .i_rst     (ARESET),
      .i_reload  (w_next != r_state),
      .i_wait    (w_wait),
      .o_timeout (w_timeout)
   );
`endif
   // next state and per-cycle error increment; a watchdog expiry overrides both
   always_comb begin
      w_next = r_state;
      w_err_inc = 2'd0;
      case (r_state)
         S_IDLE, S_DONE: w_next = start ? S_WR : r_state;
         S_WR:           w_next = ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) ? S_WR_RESP : S_WR;
         S_WR_RESP: begin
            w_next = M_AXI_BVALID ? S_RD : S_WR_RESP;
            w_err_inc = {1'b0, M_AXI_BVALID && (M_AXI_BRESP != RESP_OKAY)};
         end
         S_RD:           w_next = M_AXI_ARREADY ? S_RD_RESP : S_RD;
         S_RD_RESP: begin
            w_next = M_AXI_RVALID ? S_NEXT : S_RD_RESP;
            w_err_inc = M_AXI_RVALID ? {1'b0, M_AXI_RRESP != RESP_OKAY} + {1'b0, M_AXI_RDATA != PATTERN[r_idx[1:0]]} : 2'd0;
         end
         S_NEXT:         w_next = (r_idx + 5'd1 == LP_NUM) ? S_DONE : S_WR;
         default:        w_next = S_IDLE;
      endcase
`ifdef SELFTEST_TIMEOUT_EN
      if (w_timeout) begin
         w_next = S_DONE;
         w_err_inc = 2'd1;
      end
`endif
   end
   // state, register index, write-channel completion flags and saturating error bookkeeping
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state <= S_IDLE;
         r_idx <= '0;
         r_aw_done <= 1'b0;
         r_w_done <= 1'b0;
         r_err_count <= '0;
         r_first_fail_idx <= '0;
      end else begin
         r_state <= w_next;
         r_aw_done <= (w_next == S_WR) && (r_aw_done || w_aw_hs);
         r_w_done <= (w_next == S_WR) && (r_w_done || w_w_hs);
         if (w_accept) begin
            r_idx <= '0;
            r_err_count <= '0;
            r_first_fail_idx <= '0;
         end else begin
            if (r_state == S_NEXT) r_idx <= r_idx + 5'd1;
            if (w_err_inc != 2'd0) begin
               r_err_count <= w_err_sum[5] ? 5'd31 : w_err_sum[4:0];
               if (r_err_count == 5'd0) r_first_fail_idx <= r_idx[3:0];
            end
         end
      end
   end
   assign busy = r_state != S_IDLE && r_state != S_DONE;
   assign done = r_state == S_DONE;
   assign pass = done && r_err_count == 5'd0;
   assign err_count = r_err_count;
   assign first_fail_idx = r_first_fail_idx;
   assign M_AXI_AWADDR = w_addr;
   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_AWVALID = r_state == S_WR && !r_aw_done;
   assign M_AXI_WDATA = PATTERN[r_idx[1:0]];
   assign M_AXI_WSTRB = 4'hF;
   assign M_AXI_WVALID = r_state == S_WR && !r_w_done;
   assign M_AXI_BREADY = r_state == S_WR_RESP;
   assign M_AXI_ARADDR = w_addr;
   assign M_AXI_ARPROT = 3'b000;
   assign M_AXI_ARVALID = r_state == S_RD;
   assign M_AXI_RREADY = r_state == S_RD_RESP;
endmodule
